// File: rtl/tmds_pkg.sv
// tmds_pkg: shared TMDS symbol constants and serializer state encoding
package tmds_pkg;
  localparam int WORD_W = 10;
  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;
  localparam logic [9:0] IDLE_WORD = CTRL_00;
  localparam logic [9:0] CLK_PATTERN = 10'b0000011111;
  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;
endpackage

// File: rtl/tmds_word_fifo.sv
// tmds_word_fifo: small synchronous FIFO holding encoded word triplets
module tmds_word_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 30
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic wr, rd;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign wr = push && !full;
  assign rd = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr);
      rd_ptr <= rd_ptr + AW'(rd);
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= din;
endmodule

// File: rtl/tmds_serializer_ctrl.sv
// tmds_serializer_ctrl: buffers TMDS word triplets and shifts them out LSB first,
// padding with the idle control symbol during link sync and on underrun
module tmds_serializer_ctrl
  import tmds_pkg::*;
#(
  parameter int WORD_W = tmds_pkg::WORD_W,
  parameter int FIFO_DEPTH = 2,
  parameter logic [9:0] IDLE_WORD = tmds_pkg::IDLE_WORD,
  parameter int SYNC_WORDS = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [WORD_W-1:0] i_tmds_blue,
  input  logic [WORD_W-1:0] i_tmds_green,
  input  logic [WORD_W-1:0] i_tmds_red,
  output logic              o_blue_serial,
  output logic              o_green_serial,
  output logic              o_red_serial,
  output logic              o_pixclk_serial,
  output logic              o_word_strobe,
  output logic              o_underrun,
  output logic [7:0]        o_underrun_cnt
);
  state_t state, next;
  logic [3:0] bit_cnt;
  logic [7:0] sync_cnt;
  logic stop, boundary, load, pop, miss, flush, full, empty;
  logic [3*WORD_W-1:0] head;
  logic [WORD_W-1:0] sh_b, sh_g, sh_r, nb, ng, nr;
  logic [9:0] sh_c;
  assign boundary = state != IDLE && bit_cnt == 4'd9;
  assign o_ready = state == RUN && !full;
  assign {nr, ng, nb} = pop ? head : {3{IDLE_WORD}};
  assign o_blue_serial = sh_b[0];
  assign o_green_serial = sh_g[0];
  assign o_red_serial = sh_r[0];
  assign o_pixclk_serial = sh_c[0];
  tmds_word_fifo #(.DEPTH(FIFO_DEPTH), .W(3*WORD_W)) u_fifo (
    .clk(i_clk),
    .rst(i_rst),
    .clr(flush),
    .push(i_valid && o_ready),
    .pop(pop),
    .din({i_tmds_red, i_tmds_green, i_tmds_blue}),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    load = 1'b0;
    pop = 1'b0;
    miss = 1'b0;
    flush = 1'b0;
    if (state == IDLE) next = i_enable ? SYNC : IDLE;
    else if (boundary) begin
      if (stop || !i_enable) begin
        next = IDLE;
        flush = 1'b1;
      end else begin
        load = 1'b1;
        pop = state == RUN && !empty;
        miss = state == RUN && empty;
        if (state == SYNC && sync_cnt == 8'(SYNC_WORDS - 1)) next = RUN;
      end
    end
  end
  // Entering SYNC presets bit_cnt to 9 so the first idle word loads on the next edge
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      bit_cnt <= '0;
      sync_cnt <= '0;
      stop <= 1'b0;
      sh_b <= '0;
      sh_g <= '0;
      sh_r <= '0;
      sh_c <= '0;
      o_word_strobe <= 1'b0;
      o_underrun <= 1'b0;
      o_underrun_cnt <= '0;
    end else begin
      bit_cnt <= state == IDLE ? (i_enable ? 4'd9 : 4'd0) : (boundary ? 4'd0 : bit_cnt + 4'd1);
      sync_cnt <= state == IDLE ? 8'd0 : sync_cnt + 8'(load && state == SYNC);
      stop <= state != IDLE && !boundary && (stop || !i_enable);
      sh_b <= load ? nb : boundary ? '0 : sh_b >> 1;
      sh_g <= load ? ng : boundary ? '0 : sh_g >> 1;
      sh_r <= load ? nr : boundary ? '0 : sh_r >> 1;
      sh_c <= load ? CLK_PATTERN : boundary ? '0 : sh_c >> 1;
      o_word_strobe <= load;
      o_underrun <= miss;
      o_underrun_cnt <= o_underrun_cnt + 8'(miss && o_underrun_cnt != 8'hFF);
    end
endmodule

// File: tb/tb_tmds_serializer_ctrl.sv
// tb_tmds_serializer_ctrl: scoreboard bench; stimulus queues expected words, monitor checks each serialized word
module tb_tmds_serializer_ctrl;
  localparam logic [9:0] IDLE_W = 10'b1101010100;
  localparam logic [9:0] CLKP = 10'b0000011111;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, valid = 1'b0;
  logic [9:0] blue = '0, green = '0, red = '0;
  logic ready, s_b, s_g, s_r, s_c, strobe, under;
  logic [7:0] ucnt;
  typedef struct {logic [9:0] b, g, r; logic u;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;

  tmds_serializer_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_valid(valid), .o_ready(ready),
    .i_tmds_blue(blue), .i_tmds_green(green), .i_tmds_red(red),
    .o_blue_serial(s_b), .o_green_serial(s_g), .o_red_serial(s_r),
    .o_pixclk_serial(s_c), .o_word_strobe(strobe), .o_underrun(under),
    .o_underrun_cnt(ucnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t actual=%h required=%h", name, $time, act, req);
    end
  endtask

  task automatic expect_word(input logic [9:0] b, input logic [9:0] g, input logic [9:0] r, input logic u);
    exp_t e;
    e.b = b; e.g = g; e.r = r; e.u = u;
    q.push_back(e);
  endtask

  task automatic send(input logic [9:0] b, input logic [9:0] g, input logic [9:0] r);
    int n = 0;
    blue = b; green = g; red = r; valid = 1'b1;
    while (!ready && n < 2000) begin @(negedge clk); n++; end
    if (!ready) begin
      checks++; errors++;
      $display("FAIL send_timeout at %0t actual=ready_low required=ready_high", $time);
    end else expect_word(b, g, r, 1'b0);
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_strobes(input int k);
    int n = 0, seen = 0;
    while (seen < k && n < 300) begin
      @(negedge clk);
      n++;
      if (strobe) seen++;
    end
    check("strobe_wait", 32'(seen), 32'(k));
  endtask

  task automatic check_quiet(input string name);
    check({name, "_serial"}, {s_b, s_g, s_r, s_c}, 4'b0);
    check({name, "_pulses"}, {strobe, under, ready}, 3'b0);
  endtask

  logic [9:0] m_b, m_g, m_r, m_c;
  logic m_u, m_abort, m_have;
  exp_t m_e;
  initial forever begin
    @(negedge clk);
    if (strobe && !rst) begin
      m_have = q.size() != 0;
      if (m_have) m_e = q.pop_front();
      else begin
        checks++; errors++;
        $display("FAIL unexpected_word at %0t actual=strobe required=no_word", $time);
      end
      m_u = under;
      m_abort = 1'b0;
      for (int i = 0; i < 10; i++) begin
        if (i != 0) @(negedge clk);
        m_abort = m_abort | rst;
        m_b[i] = s_b; m_g[i] = s_g; m_r[i] = s_r; m_c[i] = s_c;
      end
      if (m_have && !m_abort) begin
        check("word_blue", m_b, m_e.b);
        check("word_green", m_g, m_e.g);
        check("word_red", m_r, m_e.r);
        check("word_pixclk", m_c, CLKP);
        check("word_underrun", m_u, m_e.u);
      end
    end
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    check("reset_cnt", ucnt, 8'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet("idle");
    repeat (4) expect_word(IDLE_W, IDLE_W, IDLE_W, 1'b0);
    en = 1'b1;
    repeat (6) send(10'h3FF, 10'h000, 10'h155);
    expect_word(IDLE_W, IDLE_W, IDLE_W, 1'b1);
    wait_strobes(3);
    send(10'h2AA, 10'h155, 10'h0F0);
    send(10'h001, 10'h200, 10'h3C3);
    send(10'h155, 10'h3FF, 10'h000);
    check("gap_cnt", ucnt, 8'd1);
    repeat (4) send(10'h3FF, 10'h000, 10'h155);
    repeat (2) @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    en = 1'b1;
    check("buffered_left", 32'(q.size()), 32'd2);
    q.delete();
    repeat (4) @(negedge clk);
    repeat (4) expect_word(IDLE_W, IDLE_W, IDLE_W, 1'b0);
    repeat (258) expect_word(IDLE_W, IDLE_W, IDLE_W, 1'b1);
    @(negedge clk);
    check_quiet("stopped");
    @(negedge clk);
    check_quiet("resync");
    n = 0;
    while (q.size() != 0 && n < 4000) begin @(posedge clk); n++; end
    check("drain_done", 32'(q.size()), 32'd0);
    check("sat_cnt", ucnt, 8'd255);
    repeat (4) @(negedge clk);
    check("pre_reset_bits", {s_b, s_c}, 2'b11);
    #2 rst = 1'b1;
    #1;
    check_quiet("async_reset");
    check("async_reset_cnt", ucnt, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    en = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tmds_serializer_ctrl.md
# tmds_serializer_ctrl

Sequences the three TMDS data channels and the TMDS clock channel into single-bit streams that feed the differential output buffer stage. It runs on the bit-rate clock (10× pixel rate). It accepts 10-bit encoded words per channel through a valid/ready handshake into a small buffer, then shifts them out LSB first. When the link starts or data runs dry, it inserts a link-training control word, so the sink never sees a broken symbol.

## Interface
- WORD_W, 10, TMDS symbol width; fixed at 10, other values unsupported
- FIFO_DEPTH, 2, input buffer depth in word triplets (power of 2, ≥2)
- IDLE_WORD, 10'b1101010100, control symbol (C1C0=00) sent during SYNC and underrun
- SYNC_WORDS, 4, idle words sent after enable before data is accepted into the shifter
- i_clk  in  1  bit-rate clock; all logic single-domain
- i_rst  in  1  asynchronous, active-high reset
- i_enable  in  1  link enable, level-sensitive
- i_valid  in  1  word triplet present on i_tmds_*
- o_ready  out  1  buffer can accept; transfer when i_valid && o_ready
- i_tmds_blue / i_tmds_green / i_tmds_red  in  10 each  encoded symbols, channel 0/1/2
- o_blue_serial / o_green_serial / o_red_serial  out  1 each  serial data to output buffers
- o_pixclk_serial  out  1  TMDS clock pattern, 5 bits high then 5 low per word
- o_word_strobe  out  1  one-cycle pulse on each word-boundary load
- o_underrun  out  1  one-cycle pulse when IDLE_WORD substituted in RUN
- o_underrun_cnt  out  8  saturating underrun count, cleared only by reset

## Operation
- bit_cnt 0..9 wraps every 10 cycles while state ≠ IDLE; word boundary = cycle where bit_cnt==9.
- States:
  - IDLE: serial outputs and clock pattern are 0. o_ready=0. Buffer empty. Exit to SYNC when i_enable=1; the first load occurs on the next cycle.
  - SYNC: load IDLE_WORD on all three channels at each boundary. Count SYNC_WORDS loads, then go to RUN. o_ready=0.
  - RUN: o_ready = buffer not full. At each boundary, pop the head triplet into the shifters; if the buffer is empty, load IDLE_WORD ×3 and pulse o_underrun.
- Disable (i_enable=0) in SYNC/RUN: finish the current word. At the boundary, go to IDLE instead of loading. Flush the buffer; serial outputs 0 from the next cycle. Re-enable during that word is ignored; it must be re-sampled in IDLE.
- Shifters: each cycle output bit[0], shift right. Bit 0 of a word is output in the cycle after the load.
- Clock shifter is reloaded with 10'b0000011111 at every boundary, LSB first, so it is high for bit_cnt 0–4 of the output word.
- Simultaneous push and pop at a boundary are both honoured, including when the buffer is full (pop frees the slot; o_ready stays combinational on the pre-pop count, so push is refused that cycle).
- o_underrun_cnt saturates at 255.

## Timing
- Reset (async assert, sync-style release on i_clk): state=IDLE, bit_cnt=0, buffer empty. All outputs 0, including o_underrun_cnt.
- Latency: a triplet accepted into an empty buffer in RUN has its bit 0 on the serial outputs 1 cycle after the next boundary (worst case 11 cycles after acceptance).
- Enable→first data bit: enable sampled in IDLE, then SYNC_WORDS×10 cycles of IDLE_WORD, then data.
- Throughput: sustained one triplet per 10 cycles; an upstream that keeps o_ready satisfied never underruns.
- o_word_strobe and o_underrun are registered, asserted in the cycle after the boundary (aligned with bit 0).

## Structure
- Shared package `tmds_pkg`: WORD_W, IDLE_WORD and the other three control symbols, CLK_PATTERN (10'b0000011111), state enum {IDLE, SYNC, RUN}.
- One sub-module, `tmds_word_fifo`: a FIFO_DEPTH×30-bit synchronous FIFO with full/empty flags, used for the input buffer.

## Test plan
- Reset mid-RUN with a non-zero pattern on the shifters → all outputs 0 in the same cycle; o_underrun_cnt=0; o_ready=0.
- Enable, no data → 4 words of 1101010100 LSB first (0,0,1,0,1,0,1,0,1,1), then o_underrun pulses every 10 cycles; count saturates at 255 after 255 words.
- Enable, stream blue=10'h3FF, green=10'h000, red=10'h155 continuously → bits exactly match after SYNC; zero underruns; clock high 5/low 5.
- Fill buffer to 2, hold i_valid at the boundary → pop occurs, push is refused that cycle, accepted the next cycle; no word lost or duplicated.
- Drop i_enable at bit_cnt=3 → current word completes through bit 9; outputs 0 from the next cycle; a buffered word is discarded.
- Insert a single gap (one missing triplet) → exactly one IDLE_WORD at that slot; o_underrun_cnt increments by 1.
